gpio_shift_out: RTL

GPIO_SHIFT_OUT -- requirements
Module: gpio_shift_out

---
 rtl/gpio_shift_out.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/gpio_shift_out.sv
// Register-mapped LED/GPIO output port with a serial shifter that clocks the
// LED image into an external shift-register chain and pulses its output latch.
module gpio_shift_out #(
   parameter int DATA_W    = 16,
   parameter int GPIO_W    = 14,
   parameter int CLK_DIV   = 4,
   parameter int MSB_FIRST = 1,
   parameter int INVERT    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Start,
   input  logic              EN,
   input  logic [31:0]       P_Data,
   output logic [1:0]        counter_set,
   output logic [DATA_W-1:0] LED_out,
   output logic [GPIO_W-1:0] GPIOf0,
   output logic              led_clk,
   output logic              led_sout,
   output logic              led_clrn,
   output logic              LED_PEN,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_e;

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic             INV_BIT  = (INVERT != 0);

   state_e              state_q, state_d;
   logic                pending_q, pending_d;
   logic [DATA_W-1:0]   led_q, led_d;
   logic [GPIO_W-1:0]   gpio_q, gpio_d;
   logic [1:0]          cset_q, cset_d;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic                clrn_q;

   logic bit_end;
   logic last_bit;
   logic cur_bit;

   assign bit_end  = (div_q == DIV_LAST);
   assign last_bit = bit_end && (bit_q == BIT_LAST);
   assign cur_bit  = (MSB_FIRST != 0) ? sh_q[DATA_W-1] : sh_q[0];

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      led_d     = led_q;
      gpio_d    = gpio_q;
      cset_d    = cset_q;
      sh_d      = sh_q;
      bit_d     = bit_q;
      div_d     = div_q;

      if (EN) begin
         led_d  = P_Data[DATA_W-1:0];
         gpio_d = P_Data[DATA_W+GPIO_W-1:DATA_W];
         cset_d = P_Data[31:30];
      end

      // Captures use led_d so a write on the starting edge is what gets shifted.
      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = SHIFT;
               sh_d    = led_d;
               bit_d   = '0;
               div_d   = '0;
            end
         end
         SHIFT: begin
            if (Start) pending_d = 1'b1;
            if (bit_end) begin
               div_d = '0;
               bit_d = bit_q + 1'b1;
               sh_d  = (MSB_FIRST != 0) ? (sh_q << 1) : (sh_q >> 1);
               if (last_bit) begin
                  state_d = LATCH;
                  bit_d   = '0;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         LATCH: begin
            // A Start seen in the latch cycle itself chains a frame like a pending one.
            pending_d = 1'b0;
            if (pending_q || Start) begin
               state_d = SHIFT;
               sh_d    = led_d;
               bit_d   = '0;
               div_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         led_q     <= '0;
         gpio_q    <= '0;
         cset_q    <= '0;
         sh_q      <= '0;
         bit_q     <= '0;
         div_q     <= '0;
         clrn_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         led_q     <= led_d;
         gpio_q    <= gpio_d;
         cset_q    <= cset_d;
         sh_q      <= sh_d;
         bit_q     <= bit_d;
         div_q     <= div_d;
         clrn_q    <= 1'b1;
      end
   end

   assign LED_out     = led_q;
   assign GPIOf0      = gpio_q;
   assign counter_set = cset_q;
   assign led_clrn    = clrn_q;
   assign led_clk     = (state_q == SHIFT) ? (div_q >= DIV_HALF) : 1'b1;
   assign led_sout    = (state_q == SHIFT) && (cur_bit ^ INV_BIT);
   assign LED_PEN     = (state_q == LATCH);
   assign busy        = (state_q != IDLE);

endmodule
